mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised load/store unit for the MEM stage, successor to the simulation-only memory hookup. It adds a registered request/acknowledge bus to real data memory, byte/half/word (and doubleword at XLEN=64) accesses with byte enables and sign extension, misalignment and bus-error faults, and a pipeline stall. It also resolves the branch decision from a branch-type field rather than a single zero flag. It sits between the EX/MEM register and the MEM/WB register.

## Interface
- XLEN, 32, data path width; legal values are 32 and 64.
- TIMEOUT_CYC, 64, maximum cycles waiting for ack (used only with MEM_TIMEOUT_EN).
- i_clk  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  MEM-stage instruction valid.
- i_memAddr  in  XLEN  effective address.
- i_wrData  in  XLEN  store data, right-aligned.
- i_ctrlMEM  in  mem_ctrl_t  fields: MemRead, MemWrite, Size (B/H/W/D), Unsigned, Branch, Jump, BrType.
- i_zero, i_lt, i_ltu  in  1 each  ALU flags.
- o_PCSrc  out  1  take branch/jump.
- o_stall  out  1  hold upstream stages.
- o_done  out  1  one-cycle pulse: access finished.
- o_readData  out  XLEN  extended load data, valid with o_done.
- o_fault  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout; valid with o_done.
- o_bus_req, o_bus_we  out  1  request, write.
- o_bus_addr  out  XLEN  word/dword-aligned address.
- o_bus_be  out  XLEN/8  byte enables.
- o_bus_wdata  out  XLEN  lane-replicated write data.
- i_bus_ack, i_bus_err  in  1  transfer complete, error (either terminates).
- i_bus_rdata  in  XLEN  read data, sampled on ack.

## Operation
- o_PCSrc is combinational: (Branch & cond) | Jump. cond is selected by BrType: EQ=i_zero, NE=!i_zero, LT=i_lt, GE=!i_lt, LTU=i_ltu, GEU=!i_ltu.
- A memory op is i_valid & (MemRead | MemWrite). MemRead and MemWrite both set is treated as a write.
- Lane offset off = addr[log2(XLEN/8)-1:0].
- Misaligned: H with off[0]; W with off[1:0]≠0; D with off≠0. Size D at XLEN=32 is also reported as misaligned.
- Byte enables are B=1<<off, H=3<<off, W=0xF<<off, D=all ones. wdata replicates the B/H/W datum across all lanes.
- Load data is shifted right by off×8, then zero-extended if Unsigned, else sign-extended from the size's MSB.
- FSM states:
  - IDLE: accepts a memory op.
    - Aligned → BUSY, latching addr, size, Unsigned, we, be and wdata.
    - Misaligned → DONE with fault 1, and no bus request is issued.
  - BUSY: o_bus_req=1 with all bus outputs driven from the latched registers.
    - ack without err → DONE, capturing the extended rdata (writes give o_readData=0).
    - err, with or without ack → DONE, fault 2.
    - Timeout → DONE, fault 3.
  - DONE: o_done=1 for one cycle, then unconditionally → IDLE. i_valid is ignored in DONE.
- o_stall = (IDLE & memory op) | BUSY. It is low in DONE, so the pipeline advances exactly on the o_done cycle.
- Non-memory valid instructions cause no stall and no o_done.

## Timing
- Reset values: state IDLE. All of o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata, o_done, o_readData and o_fault are 0. o_stall and o_PCSrc follow their combinational equations.
- Cycle 0: accept. Cycle 1: o_bus_req high. The cycle after the ack-sampling edge: o_done. Minimum aligned latency is ack in cycle 1 → o_done in cycle 2.
- Misaligned access: o_done in cycle 1, with o_stall high only in cycle 0.
- Bus outputs are stable while o_bus_req is high. o_bus_req drops in the DONE cycle.
- i_bus_ack and i_bus_err outside BUSY are ignored.
- Reset asserted mid-transfer clears o_bus_req asynchronously, with no o_done. A late ack after reset is ignored.
- o_readData and o_fault hold their values after DONE until the next DONE.

## Configuration
- MEM_TIMEOUT_EN:
  - Defined: a BUSY cycle counter of width $clog2(TIMEOUT_CYC+1) counts from 0 on BUSY entry. If the counter reaches TIMEOUT_CYC−1 with no ack or err, the next state is DONE with fault 3.
  - Undefined: no counter, BUSY waits indefinitely, and fault code 3 is never produced.

## Structure
- Shared package mem_pkg holds:
  - mem_ctrl_t;
  - size enum SZ_B/SZ_H/SZ_W/SZ_D;
  - branch enum BR_EQ/BR_NE/BR_LT/BR_GE/BR_LTU/BR_GEU;
  - fault constants FLT_NONE/FLT_MISALIGN/FLT_BUSERR/FLT_TIMEOUT;
  - the FSM state enum.
- One sub-module, mem_lane_align, is combinational. It computes misalignment, be, replicated wdata and load extension from off/size/Unsigned. It is instantiated once for the request path and once for the response path.

## Test plan
- SW 0xDEADBEEF to 0x100, ack in cycle 1 → be=0xF, wdata=0xDEADBEEF, we=1, o_done in cycle 2, fault 0, stall high in cycles 0–1.
- LB from 0x103 with rdata=0x80FFFFFF, Unsigned=0 → be=0x8, o_readData=0xFFFFFF80. The same with Unsigned=1 → 0x00000080.
- SH to 0x201 → no o_bus_req, o_done in cycle 1, fault 1. LW from 0x102 → fault 1.
- LW with i_bus_err in cycle 3 → o_done in cycle 4, fault 2. With MEM_TIMEOUT_EN and TIMEOUT_CYC=4, no ack → o_done in cycle 5 with fault 3, and req high cycles 1–4.
- Reset in cycle 2 of a pending load → req low immediately, no o_done. Ack in cycle 3 is ignored and the state stays IDLE.
- BrType=BLTU with i_ltu=1, Branch=1 → o_PCSrc=1. BNE with i_zero=1 → 0. Jump=1 → 1 regardless of flags.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: control word, size/branch
// encodings, fault codes and FSM states.
package mem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [2:0] {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} br_e;

    typedef struct packed {
        logic  MemRead;
        logic  MemWrite;
        size_e Size;
        logic  Unsigned;
        logic  Branch;
        logic  Jump;
        br_e   BrType;
    } mem_ctrl_t;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_BUSERR   = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} lsu_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: misalignment check, byte enables, write replication and
// load shift/extension from the lane offset and access size.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  size_e                     size,
    input  logic                      is_unsigned,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic                      misaligned,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           wdata_rep,
    output logic [XLEN-1:0]           rdata_ext
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]   base;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            msb;

    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        base       = '1;
        wdata_rep  = wdata;
        mask       = '1;
        msb        = sh[XLEN-1];
        case (size)
            SZ_B: begin
                base      = NB'(1);
                wdata_rep = {NB{wdata[7:0]}};
                mask      = XLEN'(8'hFF);
                msb       = sh[7];
            end
            SZ_H: begin
                misaligned = off[0];
                base       = NB'(3);
                wdata_rep  = {(XLEN/16){wdata[15:0]}};
                mask       = XLEN'(16'hFFFF);
                msb        = sh[15];
            end
            SZ_W: begin
                misaligned = |off[1:0];
                base       = NB'(4'hF);
                wdata_rep  = {(XLEN/32){wdata[31:0]}};
                mask       = XLEN'(32'hFFFF_FFFF);
                msb        = sh[31];
            end
            default: begin
                // Doubleword has no legal placement on a 32-bit bus
                misaligned = (XLEN == 32) ? 1'b1 : |off;
            end
        endcase
        be        = base << off;
        rdata_ext = (sh & mask) | ((!is_unsigned && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: registered req/ack bus master with lane steering,
// fault reporting and branch resolution. Optional bus timeout: MEM_TIMEOUT_EN.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [XLEN-1:0]   i_memAddr,
    input  logic [XLEN-1:0]   i_wrData,
    input  mem_ctrl_t         i_ctrlMEM,
    input  logic              i_zero,
    input  logic              i_lt,
    input  logic              i_ltu,
    output logic              o_PCSrc,
    output logic              o_stall,
    output logic              o_done,
    output logic [XLEN-1:0]   o_readData,
    output logic [1:0]        o_fault,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [XLEN-1:0]   o_bus_addr,
    output logic [XLEN/8-1:0] o_bus_be,
    output logic [XLEN-1:0]   o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic              i_bus_err,
    input  logic [XLEN-1:0]   i_bus_rdata
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e      state, nstate;
    logic            mem_op, req_mis, tmo, cond;
    logic [NB-1:0]   req_be;
    logic [XLEN-1:0] req_wdata, rsp_ext;

    logic [XLEN-1:0] addr_q, wdata_q, rd_q;
    logic [NB-1:0]   be_q;
    logic            we_q, uns_q;
    size_e           size_q;
    logic [1:0]      flt_q;

    logic [XLEN-1:0] req_ext_unused, rsp_wdata_unused;
    logic [NB-1:0]   rsp_be_unused;
    logic            rsp_mis_unused;

    mem_lane_align #(.XLEN(XLEN)) u_req_align (
        .off        (i_memAddr[OFFW-1:0]),
        .size       (i_ctrlMEM.Size),
        .is_unsigned(i_ctrlMEM.Unsigned),
        .wdata      (i_wrData),
        .rdata      ('0),
        .misaligned (req_mis),
        .be         (req_be),
        .wdata_rep  (req_wdata),
        .rdata_ext  (req_ext_unused)
    );

    mem_lane_align #(.XLEN(XLEN)) u_rsp_align (
        .off        (addr_q[OFFW-1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .wdata      (wdata_q),
        .rdata      (i_bus_rdata),
        .misaligned (rsp_mis_unused),
        .be         (rsp_be_unused),
        .wdata_rep  (rsp_wdata_unused),
        .rdata_ext  (rsp_ext)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)               cnt <= '0;
        else if (state != ST_BUSY) cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

    assign tmo = (cnt == CW'(TIMEOUT_CYC - 1));
`else
    localparam int TimeoutCycUnused = TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    assign mem_op  = i_valid & (i_ctrlMEM.MemRead | i_ctrlMEM.MemWrite);
    assign o_stall = ((state == ST_IDLE) & mem_op) | (state == ST_BUSY);
    assign o_done  = (state == ST_DONE);

    assign o_bus_req   = (state == ST_BUSY);
    assign o_bus_we    = we_q;
    assign o_bus_addr  = {addr_q[XLEN-1:OFFW], OFFW'(0)};
    assign o_bus_be    = be_q;
    assign o_bus_wdata = wdata_q;
    assign o_readData  = rd_q;
    assign o_fault     = flt_q;

    always_comb begin
        cond = 1'b0;
        case (i_ctrlMEM.BrType)
            BR_EQ:   cond = i_zero;
            BR_NE:   cond = !i_zero;
            BR_LT:   cond = i_lt;
            BR_GE:   cond = !i_lt;
            BR_LTU:  cond = i_ltu;
            BR_GEU:  cond = !i_ltu;
            default: cond = 1'b0;
        endcase
        o_PCSrc = (i_ctrlMEM.Branch & cond) | i_ctrlMEM.Jump;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: if (mem_op) nstate = req_mis ? ST_DONE : ST_BUSY;
            ST_BUSY: if (i_bus_ack | i_bus_err | tmo) nstate = ST_DONE;
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            rd_q    <= '0;
            flt_q   <= FLT_NONE;
        end else begin
            state <= nstate;
            if (state == ST_IDLE && mem_op) begin
                if (req_mis) begin
                    flt_q <= FLT_MISALIGN;
                    rd_q  <= '0;
                end else begin
                    addr_q  <= i_memAddr;
                    size_q  <= i_ctrlMEM.Size;
                    uns_q   <= i_ctrlMEM.Unsigned;
                    we_q    <= i_ctrlMEM.MemWrite;
                    be_q    <= req_be;
                    wdata_q <= req_wdata;
                end
            end else if (state == ST_BUSY) begin
                // Error takes priority over a simultaneous ack
                if (i_bus_err) begin
                    flt_q <= FLT_BUSERR;
                    rd_q  <= '0;
                end else if (i_bus_ack) begin
                    flt_q <= FLT_NONE;
                    rd_q  <= we_q ? '0 : rsp_ext;
                end else if (tmo) begin
                    flt_q <= FLT_TIMEOUT;
                    rd_q  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu (XLEN=32, TIMEOUT_CYC=4).
module tb_mem_lsu;
    import mem_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_memAddr = '0;
    logic [31:0] i_wrData = '0;
    mem_ctrl_t   i_ctrlMEM = '0;
    logic        i_zero = 1'b0, i_lt = 1'b0, i_ltu = 1'b0;
    logic        o_PCSrc, o_stall, o_done;
    logic [31:0] o_readData;
    logic [1:0]  o_fault;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack = 1'b0, i_bus_err = 1'b0;
    logic [31:0] i_bus_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    mem_lsu #(.XLEN(32), .TIMEOUT_CYC(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
        .i_memAddr(i_memAddr), .i_wrData(i_wrData), .i_ctrlMEM(i_ctrlMEM),
        .i_zero(i_zero), .i_lt(i_lt), .i_ltu(i_ltu),
        .o_PCSrc(o_PCSrc), .o_stall(o_stall), .o_done(o_done),
        .o_readData(o_readData), .o_fault(o_fault),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err), .i_bus_rdata(i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic mem_ctrl_t mk(input logic rd, input logic wr, input size_e sz, input logic u);
        mem_ctrl_t c;
        c          = '0;
        c.MemRead  = rd;
        c.MemWrite = wr;
        c.Size     = sz;
        c.Unsigned = u;
        return c;
    endfunction

    // Issues one op in cycle 0 and records bus/stall activity until o_done.
    task automatic run_op(input mem_ctrl_t c, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_at, input int err_at,
                          output int done_at, output int req_first, output int req_last,
                          output int stall_mask, output logic [3:0] be, output logic [31:0] bwd,
                          output logic we, output logic [31:0] baddr);
        done_at = -1; req_first = -1; req_last = -1; stall_mask = 0;
        be = '0; bwd = '0; we = 1'b0; baddr = '0;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_ctrlMEM = c; i_memAddr = addr; i_wrData = wd; i_bus_rdata = rdat;
        for (int cyc = 0; cyc < 20 && done_at < 0; cyc++) begin
            if (cyc > 0) begin
                @(posedge i_clk); #1;
                i_valid = 1'b0;
            end
            i_bus_ack = (cyc == ack_at);
            i_bus_err = (cyc == err_at);
            @(negedge i_clk);
            if (o_stall) stall_mask |= (1 << cyc);
            if (o_bus_req) begin
                if (req_first < 0) req_first = cyc;
                req_last = cyc;
                be = o_bus_be; bwd = o_bus_wdata; we = o_bus_we; baddr = o_bus_addr;
            end
            if (o_done) done_at = cyc;
        end
        i_bus_ack = 1'b0;
        i_bus_err = 1'b0;
        i_ctrlMEM = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, rf, rl, sm;
        logic [3:0] be;
        logic [31:0] wd, ad;
        logic we;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req", o_bus_req, 0);
        chk("rst_done", o_done, 0);
        chk("rst_fault", o_fault, 0);
        chk("rst_rdata", o_readData, 0);
        chk("rst_bus", {o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata}, 0);
        chk("rst_stall", o_stall, 0);
        @(posedge i_clk); #1 i_reset = 1'b0;

        // SW 0xDEADBEEF -> 0x100, ack in cycle 1
        run_op(mk(0, 1, SZ_W, 0), 32'h100, 32'hDEADBEEF, 32'h12345678, 1, -1,
               d, rf, rl, sm, be, wd, we, ad);
        chk("sw_done_cyc", d, 2);
        chk("sw_req_cyc", rf, 1);
        chk("sw_be", be, 4'hF);
        chk("sw_wdata", wd, 32'hDEADBEEF);
        chk("sw_we", we, 1);
        chk("sw_addr", ad, 32'h100);
        chk("sw_stall", sm, 3);
        chk("sw_fault", o_fault, FLT_NONE);
        chk("sw_rdata", o_readData, 0);
        chk("sw_req_done", o_bus_req, 0);

        // LB from 0x103, signed then unsigned
        run_op(mk(1, 0, SZ_B, 0), 32'h103, 0, 32'h80FFFFFF, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("lb_be", be, 4'h8);
        chk("lb_addr", ad, 32'h100);
        chk("lb_we", we, 0);
        chk("lb_rdata", o_readData, 32'hFFFFFF80);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("lb_hold_rdata", o_readData, 32'hFFFFFF80);
        chk("lb_hold_done", o_done, 0);
        run_op(mk(1, 0, SZ_B, 1), 32'h103, 0, 32'h80FFFFFF, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("lbu_rdata", o_readData, 32'h00000080);

        // Halfword loads from upper half
        run_op(mk(1, 0, SZ_H, 1), 32'h102, 0, 32'hBEEF1234, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("lhu_be", be, 4'hC);
        chk("lhu_rdata", o_readData, 32'h0000BEEF);
        run_op(mk(1, 0, SZ_H, 0), 32'h102, 0, 32'hBEEF1234, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("lh_rdata", o_readData, 32'hFFFFBEEF);

        // Sub-word stores: replication and enables, late ack
        run_op(mk(0, 1, SZ_B, 0), 32'h101, 32'h00000012, 0, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("sb_be", be, 4'h2);
        chk("sb_wdata", wd, 32'h12121212);
        run_op(mk(1, 1, SZ_H, 0), 32'h102, 32'h0000ABCD, 0, 3, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("sh_be", be, 4'hC);
        chk("sh_wdata", wd, 32'hABCDABCD);
        chk("sh_rdwr_we", we, 1);
        chk("sh_done_cyc", d, 4);
        chk("sh_req_span", {rf[7:0], rl[7:0]}, 16'h0103);

        // Misaligned accesses
        run_op(mk(0, 1, SZ_H, 0), 32'h201, 32'h1, 0, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("sh_mis_req", rf, -1);
        chk("sh_mis_done", d, 1);
        chk("sh_mis_fault", o_fault, FLT_MISALIGN);
        chk("sh_mis_stall", sm, 1);
        run_op(mk(1, 0, SZ_W, 0), 32'h102, 0, 0, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("lw_mis_fault", o_fault, FLT_MISALIGN);
        chk("lw_mis_req", rf, -1);
        run_op(mk(1, 0, SZ_D, 0), 32'h100, 0, 0, 1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("ld_mis_fault", o_fault, FLT_MISALIGN);

        // Bus error in cycle 3
        run_op(mk(1, 0, SZ_W, 0), 32'h100, 0, 32'h55AA55AA, -1, 3, d, rf, rl, sm, be, wd, we, ad);
        chk("err_done_cyc", d, 4);
        chk("err_fault", o_fault, FLT_BUSERR);
        chk("err_req_last", rl, 3);

`ifdef MEM_TIMEOUT_EN
        run_op(mk(1, 0, SZ_W, 0), 32'h100, 0, 0, -1, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("tmo_done_cyc", d, 5);
        chk("tmo_fault", o_fault, FLT_TIMEOUT);
        chk("tmo_req_span", {rf[7:0], rl[7:0]}, 16'h0104);
`else
        run_op(mk(1, 0, SZ_W, 0), 32'h100, 0, 32'h0BADF00D, 10, -1, d, rf, rl, sm, be, wd, we, ad);
        chk("slow_done_cyc", d, 11);
        chk("slow_fault", o_fault, FLT_NONE);
        chk("slow_rdata", o_readData, 32'h0BADF00D);
`endif

        // Reset during a pending load
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_ctrlMEM = mk(1, 0, SZ_W, 0); i_memAddr = 32'h100;
        @(posedge i_clk); #1 i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("rst_mid_pre_req", o_bus_req, 1);
        i_reset = 1'b1;
        #1;
        chk("rst_mid_req", o_bus_req, 0);
        chk("rst_mid_done", o_done, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0; i_bus_ack = 1'b1;
        @(negedge i_clk);
        chk("late_ack_done", o_done, 0);
        chk("late_ack_req", o_bus_req, 0);
        @(posedge i_clk); #1 i_bus_ack = 1'b0;
        @(negedge i_clk);
        chk("late_ack_done2", o_done, 0);
        chk("late_ack_fault", o_fault, 0);

        // Branch resolution on a non-memory instruction
        i_valid = 1'b1;
        i_ctrlMEM = '0; i_ctrlMEM.Branch = 1'b1; i_ctrlMEM.BrType = BR_LTU;
        i_ltu = 1'b1; i_zero = 1'b0; i_lt = 1'b0;
        #1 chk("br_ltu", o_PCSrc, 1);
        chk("nomem_stall", o_stall, 0);
        i_ctrlMEM.BrType = BR_NE; i_zero = 1'b1;
        #1 chk("br_ne", o_PCSrc, 0);
        i_ctrlMEM.BrType = BR_EQ;
        #1 chk("br_eq", o_PCSrc, 1);
        i_ctrlMEM.BrType = BR_GE; i_lt = 1'b1;
        #1 chk("br_ge", o_PCSrc, 0);
        i_ctrlMEM.BrType = BR_GEU; i_ltu = 1'b0;
        #1 chk("br_geu", o_PCSrc, 1);
        i_ctrlMEM = '0; i_ctrlMEM.Jump = 1'b1; i_ctrlMEM.BrType = BR_NE;
        #1 chk("jump", o_PCSrc, 1);
        i_ctrlMEM.Jump = 1'b0; i_ctrlMEM.BrType = BR_LTU; i_ltu = 1'b1;
        #1 chk("no_branch", o_PCSrc, 0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("nomem_done", o_done, 0);
        i_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
